// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Inhibits the bus by holding the clock low, requests to send by adding data
// low, then shifts out start, 8 data bits (LSB first), odd parity and stop on
// device-generated clock falling edges. After the stop bit it samples the
// device ACK and waits for the bus to return to idle.
//
// Handshake: send is a one-cycle request. It is accepted only while the FSM
// is in IDLE and done is low. busy rises the cycle after acceptance and falls
// together with the one-cycle done pulse. ack_err is valid with done and is
// held until the next accepted send.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  // One shared timer serves the inhibit, start and timeout intervals.
  localparam int MAX_A = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int TW    = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] STA_LAST = TW'(START_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_BITS      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    nedge_q, nedge_d;
  logic [8:0]    shift_q, shift_d;
  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;

  logic          fall;
  logic          line_idle;
  logic          accept;
  logic          timeout;

  // Two-flop synchronizers; clk_sync_q[2] keeps the previous synchronized
  // clock so a falling edge is a 1 followed by a 0.
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2clk_in};
    dat_sync_d = {dat_sync_q[0], ps2data_in};
  end

  assign fall      = clk_sync_q[2] & ~clk_sync_q[1];
  assign line_idle = clk_sync_q[1] & dat_sync_q[1];

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      nedge_q    <= '0;
      shift_q    <= '0;
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      nedge_q    <= nedge_d;
      shift_q    <= shift_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
    end
  end

  // Next state, timer, edge counter and shift register.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    nedge_d = nedge_q;
    shift_d = shift_q;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q high means a transaction ended this cycle; refuse to restart.
        if (send && !done_q) begin
          accept  = 1'b1;
          shift_d = {~^tx_data, tx_data};
          timer_d = '0;
          nedge_d = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == INH_LAST) begin
          timer_d = '0;
          state_d = S_START;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_START: begin
        if (timer_q == STA_LAST) begin
          timer_d = '0;
          nedge_d = '0;
          state_d = S_BITS;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_BITS: begin
        if (fall) begin
          timer_d = '0;
          nedge_d = nedge_q + 1'b1;
          shift_d = {1'b0, shift_q[8:1]};
          // Tenth falling edge puts the stop bit out.
          if (nedge_q == 4'd9) state_d = S_ACK;
        end else if (timer_q == TMO_LAST) begin
          timeout = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ACK: begin
        if (fall) begin
          timer_d = '0;
          nedge_d = nedge_q + 1'b1;
          state_d = S_WAIT_IDLE;
        end else if (timer_q == TMO_LAST) begin
          timeout = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (line_idle) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else if (fall) begin
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          timeout = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs, computed from the upcoming state so they line up
  // with state_q and never glitch on the pads.
  always_comb begin
    clk_oe_d  = (state_d == S_INHIBIT) || (state_d == S_START);
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    if (accept) begin
      busy_d    = 1'b1;
      ack_err_d = 1'b0;
    end
    // Request-to-send: data goes low together with the start interval.
    if (state_q == S_INHIBIT && state_d == S_START) data_oe_d = 1'b1;
    // Edges 1..9 present data bits then parity; edge 10 releases for stop.
    if (state_q == S_BITS && fall) data_oe_d = (nedge_q < 4'd9) ? ~shift_q[0] : 1'b0;
    if (state_q == S_ACK && fall) ack_err_d = dat_sync_q[1];
    if (timeout) ack_err_d = 1'b1;
    if (state_q != S_IDLE && state_d == S_IDLE) begin
      done_d    = 1'b1;
      busy_d    = 1'b0;
      data_oe_d = 1'b0;
    end
  end

  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ack_err    = ack_err_q;

endmodule
